fir_spi_ctrl: RTL
=================

# fir_spi_ctrl

Command sequencer between the SPI slave byte stream and the FIR core. Parses framed SPI commands, writes tap coefficients, hands input samples to the FIR core with a busy/valid handshake, latches results and feeds result/status bytes back to the SPI slave for shift-out. Sits in the top level between the SPI slave and the FIR datapath, clocked by the 16 MHz system clock.

## Interface
- DATA_W, 16: sample and coefficient width (two SPI bytes, MSB first).
- NTAPS, 8: number of coefficient registers in the FIR core; valid addresses 0..NTAPS-1.
- RES_W, 32: FIR result width, returned as 4 bytes MSB first.

- CLK  in  1  system clock; one clock; all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- frame_active  in  1  high while SSEL asserted (synchronised by the SPI slave).
- rx_valid  in  1  one-cycle pulse: rx_byte holds a complete received byte.
- rx_byte  in  8  received byte.
- tx_ready  in  1  one-cycle pulse: SPI slave has taken tx_byte and wants the next.
- tx_byte  out  8  next byte for SPI shift-out.
- coef_we  out  1  one-cycle coefficient write strobe.
- coef_addr  out  $clog2(NTAPS)  coefficient index.
- coef_data  out  DATA_W  coefficient value.
- smp_valid  out  1  one-cycle sample strobe to FIR core.
- smp_data  out  DATA_W  sample value, stable while pending and during smp_valid.
- fir_busy  in  1  FIR core cannot accept a sample.
- fir_done  in  1  one-cycle pulse: fir_result valid.
- fir_result  in  RES_W  FIR output.
- err  out  1  sticky protocol error flag.

## Operation
- Commands (first byte of a frame): 0x01 WR_COEF (addr, hi, lo); 0x02 PUSH (hi, lo); 0x03 READ (controller returns 4 result bytes); 0x04 STATUS (returns status byte, clears err). Any other byte: set err, go DRAIN.
- States: IDLE, CMD, C_ADDR, C_HI, C_LO, S_HI, S_LO, READ, DRAIN. IDLE->CMD on frame_active rise. Each rx_valid advances one state. After the final byte of a command -> CMD (multiple commands per frame allowed). frame_active low in any state -> IDLE, partial command discarded, no strobe issued.
- WR_COEF: addr >= NTAPS -> no coef_we, err set. Otherwise coef_we pulses with addr, {hi,lo}.
- PUSH: on lo byte, sample goes pending. smp_valid pulses on the first cycle with pending and fir_busy low; then pending clears. A new PUSH completing while still pending: new sample dropped, err set, pending sample kept.
- fir_done: fir_result -> result register, result_valid set.
- READ: result register snapshotted on the command byte; if fir_done occurs in the same cycle, the new fir_result is snapshotted. tx_byte = byte 3 (MSB); each tx_ready advances to the next byte; after 4th tx_ready -> CMD, result_valid cleared, tx_byte = status. rx_valid bytes during READ are ignored.
- Status byte = {result_valid, err, pending, fir_busy, 4'b0000}. tx_byte shows status whenever not in READ. STATUS: err clears in the cycle after the command byte; the status byte already loaded carries the pre-clear err.
- DRAIN: ignore all bytes until frame end.

## Timing
- Reset values: tx_byte 0x00, coef_we 0, coef_addr 0, coef_data 0, smp_valid 0, smp_data 0, err 0; internal result 0, result_valid 0, pending 0, state IDLE. Reset mid-frame aborts everything immediately.
- All outputs registered. coef_we: cycle after the lo rx_valid. smp_valid: earliest cycle after the lo rx_valid, then each cycle after fir_busy falls.
- tx_byte updates the cycle after the event (command byte or tx_ready) that selects it.
- rx_valid and tx_ready in the same cycle: both processed.
- Coefficient and sample bytes are raw two's complement; no width conversion.

## Test plan
- WR_COEF 0x01,0x03,0x12,0x34 -> single coef_we, coef_addr 3, coef_data 0x1234; err 0.
- WR_COEF 0x01,0x08,0xAA,0xBB (NTAPS 8) -> no coef_we, err 1; STATUS 0x04 -> tx_byte bit6 = 1, err 0 afterwards.
- PUSH 0x02,0x80,0x01 with fir_busy held high 5 cycles -> smp_valid exactly once, in the cycle after fir_busy falls, smp_data 0x8001; second PUSH while pending -> err 1, dropped.
- fir_done with fir_result 0xDEADBEEF, then READ with 4 tx_ready pulses -> tx_byte 0xDE,0xAD,0xBE,0xEF, then status with bit7 = 0.
- frame_active drops after 0x01,0x02,0x55 -> no coef_we, state IDLE; next frame WR_COEF works normally.
- RST_N low mid-READ -> all outputs zero immediately; after release tx_byte 0x00, result_valid 0.

Source files
------------

// File: rtl/fir_spi_ctrl_if.sv
// fir_spi_ctrl_if: bundles the byte-stream and FIR-core signals of fir_spi_ctrl.
//   SPI side   : frame_active, rx_valid, rx_byte, tx_ready (to ctrl); tx_byte (from ctrl)
//   Coef bus   : coef_we, coef_addr, coef_data (from ctrl)
//   Sample bus : smp_valid, smp_data (from ctrl); fir_busy (to ctrl)
//   Result     : fir_done, fir_result (to ctrl)
//   Status     : err (from ctrl)
// master = the controller, slave = the SPI slave / FIR core side.
interface fir_spi_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 8,
  parameter int RES_W  = 32
);
  logic                     frame_active;
  logic                     rx_valid;
  logic [7:0]               rx_byte;
  logic                     tx_ready;
  logic [7:0]               tx_byte;
  logic                     coef_we;
  logic [$clog2(NTAPS)-1:0] coef_addr;
  logic [DATA_W-1:0]        coef_data;
  logic                     smp_valid;
  logic [DATA_W-1:0]        smp_data;
  logic                     fir_busy;
  logic                     fir_done;
  logic [RES_W-1:0]         fir_result;
  logic                     err;

  modport master (
    input  frame_active, rx_valid, rx_byte, tx_ready, fir_busy, fir_done, fir_result,
    output tx_byte, coef_we, coef_addr, coef_data, smp_valid, smp_data, err
  );

  modport slave (
    output frame_active, rx_valid, rx_byte, tx_ready, fir_busy, fir_done, fir_result,
    input  tx_byte, coef_we, coef_addr, coef_data, smp_valid, smp_data, err
  );
endinterface

// File: rtl/fir_spi_ctrl.sv
// fir_spi_ctrl: command sequencer between the SPI slave byte stream and the FIR core.
// Parses framed commands (0x01 WR_COEF, 0x02 PUSH, 0x03 READ, 0x04 STATUS),
// writes coefficients, hands samples to the core with a busy handshake, latches
// results and returns result/status bytes for shift-out.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : fir_spi_ctrl_if.master (SPI byte stream, coef/sample buses, result, err)
// All outputs are registered.
module fir_spi_ctrl #(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 8,
  parameter int RES_W  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_spi_ctrl_if.master bus
);
  localparam int AW = $clog2(NTAPS);
  localparam logic [7:0] NTAPS_B = 8'(NTAPS);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CMD    = 4'd1,
    C_ADDR = 4'd2,
    C_HI   = 4'd3,
    C_LO   = 4'd4,
    S_HI   = 4'd5,
    S_LO   = 4'd6,
    READ   = 4'd7,
    DRAIN  = 4'd8
  } state_e;

  state_e              state_q;
  logic                frame_q;
  logic [7:0]          tx_byte_q;
  logic                coef_we_q;
  logic [AW-1:0]       coef_addr_q;
  logic [DATA_W-1:0]   coef_data_q;
  logic                smp_valid_q;
  logic [DATA_W-1:0]   smp_data_q;
  logic                err_q;
  logic [RES_W-1:0]    result_q;
  logic                result_valid_q;
  logic                pending_q;
  logic [7:0]          addr_q;
  logic [7:0]          hi_q;
  logic [1:0]          rd_idx_q;
  logic [RES_W-1:0]    snap_q;

  logic [7:0]          status_d;
  logic [RES_W-1:0]    snap_d;

  // Selects one result byte, index 0 = MSB.
  function automatic logic [7:0] res_byte(input logic [RES_W-1:0] r, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = r[31:24];
      2'd1:    b = r[23:16];
      2'd2:    b = r[15:8];
      2'd3:    b = r[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Status byte and READ snapshot source (a same-cycle fir_done wins over the stored result).
  always_comb begin
    status_d = {result_valid_q, err_q, pending_q, bus.fir_busy, 4'b0000};
    if (bus.fir_done) begin
      snap_d = bus.fir_result;
    end else begin
      snap_d = result_q;
    end
  end

  // Command FSM, sample handshake, result capture and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_q        <= 1'b0;
      tx_byte_q      <= 8'h00;
      coef_we_q      <= 1'b0;
      coef_addr_q    <= '0;
      coef_data_q    <= '0;
      smp_valid_q    <= 1'b0;
      smp_data_q     <= '0;
      err_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      pending_q      <= 1'b0;
      addr_q         <= 8'h00;
      hi_q           <= 8'h00;
      rd_idx_q       <= 2'd0;
      snap_q         <= '0;
    end else begin
      frame_q     <= bus.frame_active;
      coef_we_q   <= 1'b0;
      smp_valid_q <= 1'b0;

      if (bus.fir_done) begin
        result_q       <= bus.fir_result;
        result_valid_q <= 1'b1;
      end

      // A held sample goes out on the first cycle the core is free.
      if (pending_q && !bus.fir_busy) begin
        smp_valid_q <= 1'b1;
        pending_q   <= 1'b0;
      end

      // Outside READ the shift-out byte is reloaded with status on every byte event;
      // READ command handling below overrides this.
      if (state_q != READ && (bus.rx_valid || bus.tx_ready)) begin
        tx_byte_q <= status_d;
      end

      if (!bus.frame_active) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (!frame_q) state_q <= CMD;
          end
          CMD: begin
            if (bus.rx_valid) begin
              case (bus.rx_byte)
                8'h01: state_q <= C_ADDR;
                8'h02: state_q <= S_HI;
                8'h03: begin
                  snap_q    <= snap_d;
                  tx_byte_q <= res_byte(snap_d, 2'd0);
                  rd_idx_q  <= 2'd0;
                  state_q   <= READ;
                end
                8'h04: err_q <= 1'b0;
                default: begin
                  err_q   <= 1'b1;
                  state_q <= DRAIN;
                end
              endcase
            end
          end
          C_ADDR: begin
            if (bus.rx_valid) begin
              addr_q  <= bus.rx_byte;
              state_q <= C_HI;
            end
          end
          C_HI: begin
            if (bus.rx_valid) begin
              hi_q    <= bus.rx_byte;
              state_q <= C_LO;
            end
          end
          C_LO: begin
            if (bus.rx_valid) begin
              if (addr_q < NTAPS_B) begin
                coef_we_q   <= 1'b1;
                coef_addr_q <= addr_q[AW-1:0];
                coef_data_q <= {hi_q, bus.rx_byte};
              end else begin
                err_q <= 1'b1;
              end
              state_q <= CMD;
            end
          end
          S_HI: begin
            if (bus.rx_valid) begin
              hi_q    <= bus.rx_byte;
              state_q <= S_LO;
            end
          end
          S_LO: begin
            if (bus.rx_valid) begin
              // Busy-free core takes the sample immediately; otherwise it is held.
              if (pending_q) begin
                err_q <= 1'b1;
              end else if (bus.fir_busy) begin
                pending_q  <= 1'b1;
                smp_data_q <= {hi_q, bus.rx_byte};
              end else begin
                smp_valid_q <= 1'b1;
                smp_data_q  <= {hi_q, bus.rx_byte};
              end
              state_q <= CMD;
            end
          end
          READ: begin
            if (bus.tx_ready) begin
              if (rd_idx_q == 2'd3) begin
                state_q   <= CMD;
                tx_byte_q <= {bus.fir_done, status_d[6:0]};
                if (!bus.fir_done) result_valid_q <= 1'b0;
              end else begin
                rd_idx_q  <= rd_idx_q + 2'd1;
                tx_byte_q <= res_byte(snap_q, rd_idx_q + 2'd1);
              end
            end
          end
          DRAIN: begin
            state_q <= DRAIN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.coef_we   = coef_we_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.coef_data = coef_data_q;
  assign bus.smp_valid = smp_valid_q;
  assign bus.smp_data  = smp_data_q;
  assign bus.err       = err_q;
endmodule
